// File: rtl/clock_control_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clock_control_gen                                            |
// | Description : Time-of-day keeper with runtime 12/24-hour display mode,     |
// |               in-place mode conversion and a per-field edit mode.          |
// |               Sits between the 1 s / fast-edit pulse generators and the    |
// |               seven-segment display driver.                                |
// | Ports       : i_clk, i_reset_n (async, active low)                         |
// |               i_pulse_n  - 1 s tick        i_pulse_f  - fast edit strobe   |
// |               i_edit_tgl - RUN/EDIT toggle i_sel      - 0 ss,1 mm,2 hh,3 pm|
// |               i_inc/i_dec - edit requests  i_mode_24  - 1 = 24-hour view   |
// |               o_hh/o_mm/o_ss - fields (BCD or binary), o_pm, o_editing,    |
// |               o_day_roll - 1-cycle midnight pulse                          |
// | Option      : `define CLOCK_CONTROL_ALARM_EN adds i_alarm_arm, i_alarm_clr,|
// |               i_alarm_hh, i_alarm_mm and o_alarm.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module clock_control_gen #(
  parameter bit RESET_24 = 1'b0,  // mode register reset value (1 = 24-hour)
  parameter bit OUT_BCD  = 1'b1   // 1 = packed BCD fields, 0 = plain binary
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_pulse_n,
  input  logic       i_pulse_f,
  input  logic       i_edit_tgl,
  input  logic [1:0] i_sel,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_mode_24,
  output logic [7:0] o_hh,
  output logic [7:0] o_mm,
  output logic [7:0] o_ss,
  output logic       o_pm,
  output logic       o_editing,
`ifdef CLOCK_CONTROL_ALARM_EN
  input  logic       i_alarm_arm,
  input  logic       i_alarm_clr,
  input  logic [4:0] i_alarm_hh,
  input  logic [5:0] i_alarm_mm,
  output logic       o_alarm,
`endif
  output logic       o_day_roll
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_EDIT = 1'b1
  } state_t;

  localparam logic [1:0] C_SEL_SS = 2'd0;
  localparam logic [1:0] C_SEL_MM = 2'd1;
  localparam logic [1:0] C_SEL_HH = 2'd2;

  // Field formatting: {tens,units} BCD or zero-extended binary.
  function automatic logic [7:0] fmt_field(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 7'd10);
    units = 4'(v % 7'd10);
    if (OUT_BCD) fmt_field = {tens, units};
    else         fmt_field = {1'b0, v};
  endfunction

  // Display hour from the 0..23 store; 12h shows 0 as 12 and 13..23 as 1..11.
  function automatic logic [6:0] disp_hour(input logic [4:0] h, input logic m24);
    if (m24)               disp_hour = {2'b00, h};
    else if (h == 5'd0)    disp_hour = 7'd12;
    else if (h > 5'd12)    disp_hour = {2'b00, h - 5'd12};
    else                   disp_hour = {2'b00, h};
  endfunction

  // Minute/second edit step, wrapping 59 <-> 0.
  function automatic logic [5:0] step60(input logic [5:0] v, input logic up);
    if (up) step60 = (v == 6'd59) ? 6'd0  : v + 6'd1;
    else    step60 = (v == 6'd0)  ? 6'd59 : v - 6'd1;
  endfunction

  // Hour edit step. In 12h the step stays inside the current AM/PM half:
  // offset 0 (shown as 12) -> 1 -> ... -> 11 -> 0.
  function automatic logic [4:0] step_hour(input logic [4:0] h, input logic up,
                                           input logic m24);
    logic [4:0] base;
    logic [4:0] off;
    base = (h >= 5'd12) ? 5'd12 : 5'd0;
    off  = h - base;
    if (m24) begin
      if (up) step_hour = (h == 5'd23) ? 5'd0  : h + 5'd1;
      else    step_hour = (h == 5'd0)  ? 5'd23 : h - 5'd1;
    end else begin
      if (up) off = (off == 5'd11) ? 5'd0  : off + 5'd1;
      else    off = (off == 5'd0)  ? 5'd11 : off - 5'd1;
      step_hour = base + off;
    end
  endfunction

  localparam logic [7:0] C_HH_RST = fmt_field(disp_hour(5'd0, RESET_24));

  // Registered state
  state_t     r_state;
  logic [4:0] r_h;
  logic [5:0] r_m;
  logic [5:0] r_s;
  logic       r_mode24;
  logic       r_hold;        // tick deferred by a mode-conversion cycle
  logic       r_req_vld;
  logic       r_req_up;
  logic [1:0] r_req_sel;
  logic [7:0] r_hh;
  logic [7:0] r_mm;
  logic [7:0] r_ss;
  logic       r_pm;
  logic       r_editing;
  logic       r_day_roll;

  // Next-state wires
  state_t     w_state_nx;
  logic [4:0] w_h_nx;
  logic [5:0] w_m_nx;
  logic [5:0] w_s_nx;
  logic       w_hold_nx;
  logic       w_req_vld_nx;
  logic       w_req_up_nx;
  logic [1:0] w_req_sel_nx;
  logic       w_roll_nx;
  logic       w_sec_wrap;    // a RUN tick carried ss 59 -> 0
  logic       w_mode_chg;
  logic       w_tick;

  assign w_mode_chg = (i_mode_24 != r_mode24);
  assign w_tick     = i_pulse_n | r_hold;

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_RUN;
    else            r_state <= w_state_nx;
  end

  // Next-state and datapath
  always_comb begin
    w_state_nx   = r_state;
    w_h_nx       = r_h;
    w_m_nx       = r_m;
    w_s_nx       = r_s;
    w_hold_nx    = 1'b0;
    w_req_vld_nx = r_req_vld;
    w_req_up_nx  = r_req_up;
    w_req_sel_nx = r_req_sel;
    w_roll_nx    = 1'b0;
    w_sec_wrap   = 1'b0;

    if (r_state == S_RUN) begin
      if (w_mode_chg) begin
        // Conversion cycle: defer any tick by one cycle so none is lost.
        w_hold_nx = w_tick;
      end else if (w_tick) begin
        // A held tick and a fresh one together: apply one, hold the other.
        w_hold_nx = r_hold & i_pulse_n;
        if (r_s == 6'd59) begin
          w_s_nx     = 6'd0;
          w_sec_wrap = 1'b1;
          if (r_m == 6'd59) begin
            w_m_nx = 6'd0;
            if (r_h == 5'd23) begin
              w_h_nx    = 5'd0;
              w_roll_nx = 1'b1;
            end else begin
              w_h_nx = r_h + 5'd1;
            end
          end else begin
            w_m_nx = r_m + 6'd1;
          end
        end else begin
          w_s_nx = r_s + 6'd1;
        end
      end
    end else begin
      if (r_req_vld) begin
        if (i_pulse_f) begin
          w_req_vld_nx = 1'b0;
          case (r_req_sel)
            C_SEL_SS: w_s_nx = step60(r_s, r_req_up);
            C_SEL_MM: w_m_nx = step60(r_m, r_req_up);
            C_SEL_HH: w_h_nx = step_hour(r_h, r_req_up, r_mode24);
            default:  w_h_nx = (r_h >= 5'd12) ? r_h - 5'd12 : r_h + 5'd12;
          endcase
        end
      end else if (i_inc ^ i_dec) begin
        w_req_vld_nx = 1'b1;
        w_req_up_nx  = i_inc;
        w_req_sel_nx = i_sel;
      end
    end

    // Toggle is evaluated after any strobe application above.
    if (i_edit_tgl) begin
      if (r_state == S_RUN) begin
        w_state_nx = S_EDIT;
      end else begin
        w_state_nx   = S_RUN;
        w_req_vld_nx = 1'b0;
        w_s_nx       = 6'd0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_h        <= 5'd0;
      r_m        <= 6'd0;
      r_s        <= 6'd0;
      r_mode24   <= RESET_24;
      r_hold     <= 1'b0;
      r_req_vld  <= 1'b0;
      r_req_up   <= 1'b0;
      r_req_sel  <= 2'd0;
      r_hh       <= C_HH_RST;
      r_mm       <= 8'd0;
      r_ss       <= 8'd0;
      r_pm       <= 1'b0;
      r_editing  <= 1'b0;
      r_day_roll <= 1'b0;
    end else begin
      r_h        <= w_h_nx;
      r_m        <= w_m_nx;
      r_s        <= w_s_nx;
      r_mode24   <= i_mode_24;
      r_hold     <= w_hold_nx;
      r_req_vld  <= w_req_vld_nx;
      r_req_up   <= w_req_up_nx;
      r_req_sel  <= w_req_sel_nx;
      // Display uses the mode value being registered this edge, so the
      // conversion shows one cycle after the i_mode_24 edge.
      r_hh       <= fmt_field(disp_hour(w_h_nx, i_mode_24));
      r_mm       <= fmt_field({1'b0, w_m_nx});
      r_ss       <= fmt_field({1'b0, w_s_nx});
      r_pm       <= (w_h_nx >= 5'd12);
      r_editing  <= (w_state_nx == S_EDIT);
      r_day_roll <= w_roll_nx;
    end
  end

  assign o_hh       = r_hh;
  assign o_mm       = r_mm;
  assign o_ss       = r_ss;
  assign o_pm       = r_pm;
  assign o_editing  = r_editing;
  assign o_day_roll = r_day_roll;

`ifdef CLOCK_CONTROL_ALARM_EN
  logic r_alarm;
  logic w_alarm_nx;

  // Only a RUN tick landing on hh:mm:00 can fire; clear wins over set.
  always_comb begin
    w_alarm_nx = r_alarm;
    if (w_sec_wrap && i_alarm_arm &&
        (w_h_nx == i_alarm_hh) && (w_m_nx == i_alarm_mm))
      w_alarm_nx = 1'b1;
    if (i_alarm_clr || !i_alarm_arm)
      w_alarm_nx = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_alarm <= 1'b0;
    else            r_alarm <= w_alarm_nx;
  end

  assign o_alarm = r_alarm;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_control_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_clock_control_gen                                         |
// | Description : Directed self-checking bench for clock_control_gen          |
// |               (default parameters: 12h reset mode, BCD outputs).           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_clock_control_gen;

  logic       clk;
  logic       i_reset_n;
  logic       i_pulse_n;
  logic       i_pulse_f;
  logic       i_edit_tgl;
  logic [1:0] i_sel;
  logic       i_inc;
  logic       i_dec;
  logic       i_mode_24;
  logic [7:0] o_hh;
  logic [7:0] o_mm;
  logic [7:0] o_ss;
  logic       o_pm;
  logic       o_editing;
  logic       o_day_roll;
`ifdef CLOCK_CONTROL_ALARM_EN
  logic       i_alarm_arm;
  logic       i_alarm_clr;
  logic [4:0] i_alarm_hh;
  logic [5:0] i_alarm_mm;
  logic       o_alarm;
`endif

  int total;
  int bad;
  int rolls;

  clock_control_gen dut (
    .i_clk      (clk),
    .i_reset_n  (i_reset_n),
    .i_pulse_n  (i_pulse_n),
    .i_pulse_f  (i_pulse_f),
    .i_edit_tgl (i_edit_tgl),
    .i_sel      (i_sel),
    .i_inc      (i_inc),
    .i_dec      (i_dec),
    .i_mode_24  (i_mode_24),
    .o_hh       (o_hh),
    .o_mm       (o_mm),
    .o_ss       (o_ss),
    .o_pm       (o_pm),
    .o_editing  (o_editing),
`ifdef CLOCK_CONTROL_ALARM_EN
    .i_alarm_arm(i_alarm_arm),
    .i_alarm_clr(i_alarm_clr),
    .i_alarm_hh (i_alarm_hh),
    .i_alarm_mm (i_alarm_mm),
    .o_alarm    (o_alarm),
`endif
    .o_day_roll (o_day_roll)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    i_pulse_n = 1'b1;
    for (int k = 0; k < n; k++) begin
      cyc();
      if (o_day_roll) rolls++;
    end
    i_pulse_n = 1'b0;
  endtask

  task automatic toggle_edit();
    i_edit_tgl = 1'b1;
    cyc();
    i_edit_tgl = 1'b0;
  endtask

  // One edit request followed by one fast strobe.
  task automatic edit_op(input logic [1:0] sel, input logic up);
    i_sel = sel;
    if (up) i_inc = 1'b1;
    else    i_dec = 1'b1;
    cyc();
    i_inc = 1'b0;
    i_dec = 1'b0;
    i_pulse_f = 1'b1;
    cyc();
    i_pulse_f = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; rolls = 0;
    clk = 1'b0;
    i_reset_n = 1'b1;
    i_pulse_n = 1'b0; i_pulse_f = 1'b0; i_edit_tgl = 1'b0;
    i_sel = 2'd0; i_inc = 1'b0; i_dec = 1'b0; i_mode_24 = 1'b0;
`ifdef CLOCK_CONTROL_ALARM_EN
    i_alarm_arm = 1'b0; i_alarm_clr = 1'b0; i_alarm_hh = 5'd0; i_alarm_mm = 6'd0;
`endif
    #1 i_reset_n = 1'b0;
    #2;
    check("rst_hh", {24'd0, o_hh}, 32'h12);
    check("rst_mm", {24'd0, o_mm}, 32'h00);
    check("rst_ss", {24'd0, o_ss}, 32'h00);
    check("rst_pm", {31'd0, o_pm}, 32'd0);
    check("rst_edit", {31'd0, o_editing}, 32'd0);
    check("rst_roll", {31'd0, o_day_roll}, 32'd0);
    @(posedge clk);
    #1 i_reset_n = 1'b1;

    // Half a day: midnight -> noon
    ticks(43200);
    check("noon_hh", {24'd0, o_hh}, 32'h12);
    check("noon_mm", {24'd0, o_mm}, 32'h00);
    check("noon_ss", {24'd0, o_ss}, 32'h00);
    check("noon_pm", {31'd0, o_pm}, 32'd1);
    check("noon_rolls", rolls, 32'd0);
    // Noon -> midnight, roll pulse on the final tick only
    rolls = 0;
    ticks(43200);
    check("mid_roll_now", {31'd0, o_day_roll}, 32'd1);
    check("mid_hh", {24'd0, o_hh}, 32'h12);
    check("mid_pm", {31'd0, o_pm}, 32'd0);
    check("mid_rolls", rolls, 32'd1);
    cyc();
    check("mid_roll_1cyc", {31'd0, o_day_roll}, 32'd0);

    // 24h mode, set 23:59:xx via edit
    i_mode_24 = 1'b1;
    cyc();
    check("m24_hh", {24'd0, o_hh}, 32'h00);
    toggle_edit();
    check("edit_on", {31'd0, o_editing}, 32'd1);
    edit_op(2'd2, 1'b0);
    check("e24_hh_dec", {24'd0, o_hh}, 32'h23);
    check("e24_pm", {31'd0, o_pm}, 32'd1);
    edit_op(2'd1, 1'b0);
    check("e_mm_dec", {24'd0, o_mm}, 32'h59);
    toggle_edit();
    check("exit_ss", {24'd0, o_ss}, 32'h00);
    ticks(59);
    check("pre_roll_ss", {24'd0, o_ss}, 32'h59);
    rolls = 0;
    ticks(1);
    check("r24_roll", {31'd0, o_day_roll}, 32'd1);
    check("r24_hh", {24'd0, o_hh}, 32'h00);
    check("r24_mm", {24'd0, o_mm}, 32'h00);
    check("r24_ss", {24'd0, o_ss}, 32'h00);

    // Back to 12h with a tick in the conversion cycle
    i_mode_24 = 1'b0;
    i_pulse_n = 1'b1;
    cyc();
    i_pulse_n = 1'b0;
    check("conv_hh", {24'd0, o_hh}, 32'h12);
    check("conv_pm", {31'd0, o_pm}, 32'd0);
    check("conv_ss_held", {24'd0, o_ss}, 32'h00);
    cyc();
    check("conv_ss_applied", {24'd0, o_ss}, 32'h01);

    // 12h hour editing at 12 AM
    toggle_edit();
    edit_op(2'd2, 1'b0);
    check("h12_dec", {24'd0, o_hh}, 32'h11);
    check("h12_dec_pm", {31'd0, o_pm}, 32'd0);
    edit_op(2'd2, 1'b1);
    check("h12_inc1", {24'd0, o_hh}, 32'h12);
    edit_op(2'd2, 1'b1);
    check("h12_inc2", {24'd0, o_hh}, 32'h01);
    check("h12_inc2_pm", {31'd0, o_pm}, 32'd0);
    i_inc = 1'b1; i_dec = 1'b1;
    cyc();
    i_inc = 1'b0; i_dec = 1'b0;
    i_pulse_f = 1'b1;
    cyc();
    i_pulse_f = 1'b0;
    check("incdec_ignored", {24'd0, o_hh}, 32'h01);
    edit_op(2'd3, 1'b0);
    check("half_hh", {24'd0, o_hh}, 32'h01);
    check("half_pm", {31'd0, o_pm}, 32'd1);
    edit_op(2'd3, 1'b1);
    check("half_back_pm", {31'd0, o_pm}, 32'd0);

    // Pending request behaviour
    i_sel = 2'd1;
    i_inc = 1'b1;
    cyc();
    i_inc = 1'b0;
    cyc(); cyc();
    check("no_strobe_mm", {24'd0, o_mm}, 32'h00);
    i_inc = 1'b1;
    cyc();
    i_inc = 1'b0;
    i_pulse_f = 1'b1;
    cyc();
    check("one_step_mm", {24'd0, o_mm}, 32'h01);
    cyc();
    i_pulse_f = 1'b0;
    check("no_pending_mm", {24'd0, o_mm}, 32'h01);
    ticks(3);
    check("frozen_ss", {24'd0, o_ss}, 32'h01);
    toggle_edit();
    check("exit2_ss", {24'd0, o_ss}, 32'h00);
    check("exit2_mm", {24'd0, o_mm}, 32'h01);
    check("exit2_hh", {24'd0, o_hh}, 32'h01);
    check("exit2_edit", {31'd0, o_editing}, 32'd0);

    // Strobe application and toggle in the same cycle
    toggle_edit();
    i_sel = 2'd1;
    i_inc = 1'b1;
    cyc();
    i_inc = 1'b0;
    i_pulse_f = 1'b1; i_edit_tgl = 1'b1;
    cyc();
    i_pulse_f = 1'b0; i_edit_tgl = 1'b0;
    check("tgl_apply_mm", {24'd0, o_mm}, 32'h02);
    check("tgl_apply_edit", {31'd0, o_editing}, 32'd0);

    // Async reset mid-edit with a pending request
    toggle_edit();
    i_sel = 2'd1;
    i_inc = 1'b1;
    cyc();
    i_inc = 1'b0;
    #2 i_reset_n = 1'b0;
    #1;
    check("arst_edit", {31'd0, o_editing}, 32'd0);
    check("arst_hh", {24'd0, o_hh}, 32'h12);
    check("arst_mm", {24'd0, o_mm}, 32'h00);
    @(posedge clk);
    #1 i_reset_n = 1'b1;
    i_pulse_f = 1'b1;
    cyc();
    i_pulse_f = 1'b0;
    check("arst_no_late_mm", {24'd0, o_mm}, 32'h00);
    check("arst_run", {31'd0, o_editing}, 32'd0);

`ifdef CLOCK_CONTROL_ALARM_EN
    i_alarm_hh = 5'd7; i_alarm_mm = 6'd30; i_alarm_arm = 1'b1;
    toggle_edit();
    for (int k = 0; k < 7; k++) edit_op(2'd2, 1'b1);
    for (int k = 0; k < 29; k++) edit_op(2'd1, 1'b1);
    toggle_edit();
    check("al_set_hh", {24'd0, o_hh}, 32'h07);
    check("al_set_mm", {24'd0, o_mm}, 32'h29);
    ticks(59);
    check("al_quiet", {31'd0, o_alarm}, 32'd0);
    ticks(1);
    check("al_fire", {31'd0, o_alarm}, 32'd1);
    check("al_fire_mm", {24'd0, o_mm}, 32'h30);
    cyc();
    check("al_hold", {31'd0, o_alarm}, 32'd1);
    i_alarm_clr = 1'b1; i_pulse_n = 1'b1;
    cyc();
    i_alarm_clr = 1'b0; i_pulse_n = 1'b0;
    check("al_clr", {31'd0, o_alarm}, 32'd0);
    check("al_clr_ss", {24'd0, o_ss}, 32'h01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_control_gen.md
Name: clock_control_gen

Overview:
- Parametrised successor to the 12-hour clock controller: time-of-day keeper with runtime 12/24-hour mode, in-place mode conversion, and an edit mode with increment and decrement per field.
- Sits between the pulse generators (1 s tick, fast edit strobe) and the seven-segment display driver.
- Outputs are registered hh/mm/ss fields, an AM/PM flag and a midnight roll pulse.

Parameters:
- RESET_24, 0, mode-register reset value (1 = 24-hour).
- OUT_BCD, 1, 1 = fields output as packed BCD {tens,units}; 0 = plain binary in 8 bits.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_pulse_n  in  1  1-cycle strobe, once per second.
- i_pulse_f  in  1  1-cycle fast edit strobe.
- i_edit_tgl  in  1  1-cycle pulse; toggles RUN/EDIT.
- i_sel  in  2  edit field select: 0 ss, 1 mm, 2 hh, 3 pm.
- i_inc  in  1  1-cycle increment request.
- i_dec  in  1  1-cycle decrement request.
- i_mode_24  in  1  level; 1 = 24-hour display.
- o_hh, o_mm, o_ss  out  8 each  time fields.
- o_pm  out  1  PM flag.
- o_editing  out  1  high in EDIT.
- o_day_roll  out  1  1-cycle pulse on midnight rollover.

Behaviour:
- Async reset: time 00:00:00 (midnight), state RUN, mode register = RESET_24, no requests pending.
  - Output values at reset: o_hh = 12 if RESET_24=0, else 00; o_mm = o_ss = 0; o_pm = 0; o_editing = 0; o_day_roll = 0.
- Internal hour store is 0..23. The display hour is derived from the registered mode:
  - 12h: 0 → 12, 13..23 → h−12; o_pm = (h ≥ 12).
  - 24h: displays h directly; o_pm still = (h ≥ 12).
- Mode change:
  - i_mode_24 is registered. The display conversion appears 1 cycle after an i_mode_24 edge; the stored time is never altered.
  - An i_pulse_n arriving in that cycle is held and applied next cycle; ticks are never lost.
- RUN state:
  - On i_pulse_n, ss increments. At 59 it wraps to 0 and carries to mm. mm carries to hh at 59. hh wraps 23 → 0.
  - The 11:59:59 → 12:00:00 transition sets pm (12h view 11 AM → 12 PM).
  - On wrap to 00:00:00, o_day_roll pulses high for exactly one cycle; it is registered, in the cycle the new time appears.
- EDIT state (entered and left by i_edit_tgl):
  - i_pulse_n is ignored; the clock is frozen.
  - i_inc or i_dec latches one pending request (direction plus i_sel sampled with it). It is applied on the next i_pulse_f, then cleared.
  - Requests arriving while one is pending are ignored.
  - i_inc and i_dec in the same cycle are ignored.
- Edit arithmetic, with no carry between fields:
  - ss and mm wrap 59↔0.
  - hh in 24h wraps 23↔0.
  - hh in 12h steps the display 12→1→…→11→12 (and the reverse), keeping the AM/PM half unchanged.
  - sel 3 toggles the half (h ± 12) regardless of direction.
- Leaving EDIT clears any pending request and resets ss to 0; mm and hh are retained. The next i_pulse_n counts from :00.
- i_edit_tgl coinciding with an i_pulse_f application: the application happens first, then the state toggles.
- Reset mid-edit returns to RUN immediately at midnight.
- Outputs and state are all registered. Field latency from tick or strobe to output is 1 cycle.

Optional Feature:
- Macro: CLOCK_CONTROL_ALARM_EN.
- Enabled, adds these ports:
  - i_alarm_arm  in  1.
  - i_alarm_clr  in  1.
  - i_alarm_hh  in  5 (binary 0..23).
  - i_alarm_mm  in  6 (binary).
  - o_alarm  out  1.
- Alarm set: in RUN, armed, when a tick produces hh:mm:00 equal to the alarm time, o_alarm sets on the same cycle the time updates.
- Alarm clear: o_alarm holds until i_alarm_clr, i_alarm_arm deasserting, or reset. Clear has priority over a simultaneous set.
- Editing never fires the alarm.
- Disabled: the ports are absent, with no alarm logic.

Test Plan:
- Reset in 12h mode → o_hh=0x12, o_mm=0x00, o_ss=0x00, o_pm=0. Apply 43200 ticks → 12:00:00, o_pm=1, no o_day_roll. Apply 43200 more → 12:00:00, o_pm=0, o_day_roll high for 1 cycle.
- Set 23:59:59 in 24h mode; tick → 00:00:00 with o_day_roll. Raise i_mode_24=0 → one cycle later o_hh=0x12, o_pm=0. A tick sent in the conversion cycle gives 12:00:01 one cycle later.
- EDIT, sel=2, 12h at 12 AM: dec then strobe → 11, o_pm=0. inc ×2 → 12 then 1, o_pm unchanged. Send inc+dec together → no change.
- EDIT: i_inc pulse with no i_pulse_f → no change. Second inc before strobe → one step only on strobe. i_pulse_n during EDIT → ss frozen. Exit → ss=00.
- Async reset asserted mid-EDIT with a pending request → immediate RUN, midnight, o_editing=0, no late application after release.
- CLOCK_CONTROL_ALARM_EN: alarm 07:30, armed, time 07:29:59 → tick sets o_alarm. i_alarm_clr and the next tick together → o_alarm=0.
